// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache (2**SET_BITS lines x 128 bits) refilled over a READ/BUSYWAIT block handshake.
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit_count / miss_count performance counters.
module instruction_cache_controller #(
    parameter int SET_BITS = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int TAG_BITS = 28 - SET_BITS;
    localparam int LINES    = 1 << SET_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;
    state_t state_reg, state_next;

    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_reg  [LINES];
    logic [127:0]        data_reg [LINES];
    logic [127:0]        fill_reg;
    logic [31:0]         readdata_reg;

    logic [1:0]          offset;
    logic [SET_BITS-1:0] index;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         line_words [4];
    logic                hit;
    logic                fill_capture;
    logic                line_write;

    assign offset = address[3:2];
    assign index  = address[4+SET_BITS-1:4];
    assign tag    = address[31:4+SET_BITS];

    // Lines are read combinationally so a hit returns in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign line_words[gi] = data_reg[index][32*gi +: 32];
        end
    endgenerate

    assign hit          = (state_reg == S_IDLE) && read && !reset &&
                          valid_reg[index] && (tag_reg[index] == tag);
    assign fill_capture = (state_reg == S_MEM_READ) && !mem_busywait && !reset;
    assign line_write   = (state_reg == S_UPDATE) && !reset;
    assign readdata     = hit ? line_words[offset] : readdata_reg;

    always_comb begin
        state_next  = state_reg;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        case (state_reg)
            S_IDLE: begin
                if (read && !hit) begin
                    busywait   = 1'b1;
                    state_next = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = address[31:4];
                if (!mem_busywait) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                busywait   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Reset silences the memory side immediately and abandons any refill.
        if (reset) begin
            busywait    = 1'b0;
            mem_read    = 1'b0;
            mem_address = '0;
            state_next  = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            valid_reg    <= '0;
            readdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (hit)        readdata_reg     <= line_words[offset];
            if (line_write) valid_reg[index] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; valid_reg alone qualifies it.
    always_ff @(posedge clk) begin
        if (fill_capture) fill_reg <= mem_readdata;
        if (line_write) begin
            tag_reg[index]  <= tag;
            data_reg[index] <= fill_reg;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit) hit_count_reg <= hit_count_reg + 32'd1;
            if ((state_reg == S_IDLE) && (state_next == S_MEM_READ))
                miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Scoreboard bench for instruction_cache_controller: directed cold/hit/conflict/reset cases, then random fetches
// checked against a set/tag reference model and a memory that returns word A at byte address A.
module tb_instruction_cache_controller;
    localparam int MEM_BUSY   = 5;
    // Stall cycles of a miss: miss-detect cycle, MEM_BUSY busy cycles, data-delivery cycle, update cycle.
    localparam int MISS_STALL = MEM_BUSY + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    instruction_cache_controller dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    // Memory model: busy for MEM_BUSY cycles of each read, then presents the block.
    int          mem_cnt = 0;
    logic [31:0] mem_base;
    assign mem_busywait = mem_read && (mem_cnt < MEM_BUSY);
    assign mem_base     = {mem_address, 4'b0000};
    assign mem_readdata = {mem_base + 32'd12, mem_base + 32'd8, mem_base + 32'd4, mem_base};
    always @(posedge clk) begin
        if (!mem_read)         mem_cnt <= 0;
        else if (mem_busywait) mem_cnt <= mem_cnt + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        int          mcyc;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic        mvalid [8];
    logic [24:0] mtag   [8];
    int          exp_hits    = 0;
    int          exp_misses  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Entered and left just after a posedge; leaves read asserted.
    task automatic fetch(input logic [31:0] a);
        int          idx;
        logic [24:0] tg;
        bit          h;
        exp_t        e;
        int          cycles;
        idx    = int'(a[6:4]);
        tg     = a[31:7];
        h      = mvalid[idx] && (mtag[idx] == tg);
        e.addr = a;
        e.data = {a[31:2], 2'b00};
        e.stall = h ? 0 : MISS_STALL;
        e.mcyc  = h ? 0 : MEM_BUSY + 1;
        sb_q.push_back(e);
        if (!h) exp_misses++;
        exp_hits++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        read    = 1'b1;
        address = a;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (busywait && cycles < 40);
        if (busywait) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: addr 0x%08h still stalled after %0d cycles, required at most %0d",
                     a, cycles, MISS_STALL + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        read    = 1'b0;
        address = $urandom;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard pop per completed fetch, plus idle and memory-port checks.
    initial begin
        int          wait_cnt;
        int          mr_cnt;
        logic [31:0] last_rd;
        exp_t        e;
        wait_cnt = 0;
        mr_cnt   = 0;
        last_rd  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wait_cnt = 0;
                mr_cnt   = 0;
                last_rd  = '0;
            end else begin
                if (read || mem_read)
                    check("mem_address", {4'h0, mem_address},
                          mem_read ? {4'h0, address[31:4]} : 32'h0);
                if (mem_read) mr_cnt++;
                if (read && busywait) begin
                    wait_cnt++;
                end else if (read) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: readdata 0x%08h with no fetch pending, required none",
                                 readdata);
                    end else begin
                        e = sb_q.pop_front();
                        check("readdata", readdata, e.data);
                        check("stall_cycles", wait_cnt, e.stall);
                        check("mem_read_cycles", mr_cnt, e.mcyc);
                        $display("fetch addr=0x%08h data=0x%08h stall=%0d", e.addr, readdata, wait_cnt);
                        last_rd = e.data;
                    end
                    wait_cnt = 0;
                    mr_cnt   = 0;
                end else begin
                    check("idle_busywait", {31'h0, busywait}, 32'h0);
                    check("idle_mem_read", {31'h0, mem_read}, 32'h0);
                    check("idle_readdata_hold", readdata, last_rd);
                    wait_cnt = 0;
                    mr_cnt   = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          cycles;
        reset   = 1'b1;
        read    = 1'b0;
        address = '0;
        model_reset();
        @(negedge clk);
        check("reset_busywait", {31'h0, busywait}, 32'h0);
        check("reset_mem_read", {31'h0, mem_read}, 32'h0);
        check("reset_mem_address", {4'h0, mem_address}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_readdata", readdata, 32'h0);
        @(posedge clk);
        #1;

        // Cold miss, same-line hits, conflict refills.
        fetch(32'h0000_0004);
        fetch(32'h0000_0000);
        fetch(32'h0000_0008);
        fetch(32'h0000_000C);
        fetch(32'h0000_0080);
        fetch(32'h0000_0004);
        idle(3);

        // Reset during the second MEM_READ cycle of a refill.
        a       = 32'h4000_0010;
        read    = 1'b1;
        address = a;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!mem_read && cycles < 10);
        check("abort_mem_read_seen", {31'h0, mem_read}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        @(negedge clk);
        check("abort_reset_mem_read", {31'h0, mem_read}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_next_mem_read", {31'h0, mem_read}, 32'h0);
        check("abort_next_busywait", {31'h0, busywait}, 32'h0);
        @(posedge clk);
        #1;
        fetch(a);
        fetch(32'h0000_0004);

        // Random fetches with occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            fetch(a);
        end
        idle(4);

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
`ifdef ICACHE_PERF_CNT_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
